multi_decade_down_counter: RTL and testbench

MULTI_DECADE_DOWN_COUNTER -- requirements
Module: multi_decade_down_counter

---
 rtl/multi_decade_down_counter.sv | 121 ++++++++++++
 tb/tb_multi_decade_down_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multi_decade_down_counter.sv
// multi_decade_down_counter: three-digit BCD down counter with prescaler, IDLE/RUN/DONE FSM; `define BCD_DOWN_AUTO_RELOAD_EN for auto-reload at terminal count
module multi_decade_down_counter #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_hundreds,
    input  logic       start,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    state_t      r_state, w_state_nxt;
    logic [11:0] r_cnt, w_cnt_nxt, w_load_val, w_dec;
    logic [15:0] r_presc, w_presc_nxt;
    logic        r_busy, r_done, w_done_nxt, w_last;
    logic [3:0]  w_o, w_t, w_h;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
    logic [11:0] r_pre, w_pre_nxt;
`endif
    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction
    assign w_o = r_cnt[3:0];
    assign w_t = r_cnt[7:4];
    assign w_h = r_cnt[11:8];
    assign w_load_val = {clamp9(load_hundreds), clamp9(load_tens), clamp9(load_ones)};
    assign w_last = (r_cnt == 12'h001);
    assign w_dec = {(w_o == 4'd0 && w_t == 4'd0) ? w_h - 4'd1 : w_h,
                    (w_o == 4'd0) ? ((w_t == 4'd0) ? 4'd9 : w_t - 4'd1) : w_t,
                    (w_o == 4'd0) ? 4'd9 : w_o - 4'd1};
    assign ones     = r_cnt[3:0];
    assign tens     = r_cnt[7:4];
    assign hundreds = r_cnt[11:8];
    assign busy     = r_busy;
    assign done     = r_done;
    // Next-state, next-count and terminal-count decisions; load overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_presc_nxt = r_presc;
        w_done_nxt  = r_done;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
        w_pre_nxt   = r_pre;
`endif
        if (load) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = w_load_val;
            w_presc_nxt = '0;
            w_done_nxt  = 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            w_pre_nxt   = w_load_val;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = (r_cnt == 12'h000) ? DONE : RUN;
                        w_done_nxt  = (r_cnt == 12'h000);
                    end
                end
                RUN: begin
`ifdef BCD_DOWN_AUTO_RELOAD_EN
                    w_done_nxt = 1'b0;
`endif
                    if (enable) begin
                        if (r_presc == TICK_LAST) begin
                            w_presc_nxt = '0;
                            if (w_last) begin
`ifdef BCD_DOWN_AUTO_RELOAD_EN
                                w_cnt_nxt   = r_pre;
                                w_done_nxt  = 1'b1;
`else
                                w_cnt_nxt   = 12'h000;
                                w_state_nxt = DONE;
                                w_done_nxt  = 1'b1;
`endif
                            end else begin
                                w_cnt_nxt = w_dec;
                            end
                        end else begin
                            w_presc_nxt = r_presc + 16'd1;
                        end
                    end
                end
                DONE: w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end
    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_presc <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            r_pre   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_presc <= w_presc_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= w_done_nxt;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            r_pre   <= w_pre_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_multi_decade_down_counter.sv
// tb_multi_decade_down_counter: drives TICK_DIV=1 and TICK_DIV=4 instances in lockstep against an integer-valued reference model
module tb_multi_decade_down_counter;
    logic       clk, reset_n, enable, load, start;
    logic [3:0] l_o, l_t, l_h;
    logic [3:0] o_ones [2];
    logic [3:0] o_tens [2];
    logic [3:0] o_hund [2];
    logic       o_busy [2];
    logic       o_done [2];
    int  n_tests = 0, n_fail = 0;
    int  m_val [2], m_pre [2], m_tick [2], m_st [2];
    bit  m_done [2];
    int  div [2] = '{1, 4};

    multi_decade_down_counter #(.TICK_DIV(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .load_ones(l_o), .load_tens(l_t), .load_hundreds(l_h), .start(start),
        .ones(o_ones[0]), .tens(o_tens[0]), .hundreds(o_hund[0]),
        .busy(o_busy[0]), .done(o_done[0]));
    multi_decade_down_counter #(.TICK_DIV(4)) u_d4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .load_ones(l_o), .load_tens(l_t), .load_hundreds(l_h), .start(start),
        .ones(o_ones[1]), .tens(o_tens[1]), .hundreds(o_hund[1]),
        .busy(o_busy[1]), .done(o_done[1]));

    initial clk = 1'b0;
    // Free-running clock
    always #5 clk = ~clk;

    function automatic int clampi(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Reference: value kept as a plain integer 0..999; states 0=idle 1=run 2=done
    task automatic model_step(input int k);
        if (!reset_n) begin
            m_val[k] = 0; m_pre[k] = 0; m_tick[k] = 0; m_st[k] = 0; m_done[k] = 0;
        end else if (load) begin
            m_val[k] = clampi(l_h) * 100 + clampi(l_t) * 10 + clampi(l_o);
            m_pre[k] = m_val[k]; m_tick[k] = 0; m_done[k] = 0; m_st[k] = 0;
        end else if (m_st[k] == 0) begin
            if (start) begin
                m_st[k] = (m_val[k] == 0) ? 2 : 1;
                m_done[k] = (m_val[k] == 0);
            end
        end else if (m_st[k] == 1) begin
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            m_done[k] = 0;
`endif
            if (enable) begin
                m_tick[k]++;
                if (m_tick[k] == div[k]) begin
                    m_tick[k] = 0;
                    m_val[k]--;
                    if (m_val[k] == 0) begin
                        m_done[k] = 1;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
                        m_val[k] = m_pre[k];
`else
                        m_st[k] = 2;
`endif
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [11:0] obs, input logic [11:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst=%0d got=%h exp=%h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("count", k, {o_hund[k], o_tens[k], o_ones[k]}, to_bcd(m_val[k]));
            chk("busy", k, 12'(o_busy[k]), 12'(m_st[k] == 1));
            chk("done", k, 12'(o_done[k]), 12'(m_done[k]));
        end
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        l_h = h; l_t = t; l_o = o; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bit hit;
        reset_n = 1'b0; enable = 1'b0; load = 1'b0; start = 1'b0;
        l_o = 4'd0; l_t = 4'd0; l_h = 4'd0;
        repeat (2) tick();
        reset_n = 1'b1;
        enable = 1'b1;
        do_load(4'd1, 4'd2, 4'd3);
        do_start();
        repeat (126) tick();
        do_load(4'd1, 4'd0, 4'd0);
        do_start();
        repeat (3) tick();
        do_load(4'd0, 4'd1, 4'd0);
        do_start();
        repeat (3) tick();
        do_load(4'hA, 4'hF, 4'hC);
        chk("clamp", 0, {o_hund[0], o_tens[0], o_ones[0]}, 12'h999);
        do_load(4'd0, 4'd0, 4'd0);
        do_start();
        chk("zero_done", 0, 12'(o_done[0]), 12'h001);
        repeat (3) tick();
        do_load(4'd0, 4'd0, 4'd2);
        do_start();
        repeat (5) tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (12) tick();
        do_load(4'd0, 4'd5, 4'd0);
        do_start();
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if ({o_hund[0], o_tens[0], o_ones[0]} == 12'h040) hit = 1'b1;
            else tick();
        end
        chk("reach_040", 0, 12'(hit), 12'h001);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst_count", 0, {o_hund[0], o_tens[0], o_ones[0]}, 12'h000);
        load = 1'b1; start = 1'b1; l_h = 4'd0; l_t = 4'd0; l_o = 4'd7;
        tick();
        load = 1'b0; start = 1'b0;
        chk("load_wins_busy", 0, 12'(o_busy[0]), 12'h000);
        tick();
        do_load(4'd0, 4'd0, 4'd3);
        do_start();
        repeat (14) tick();
        for (int i = 0; i < 500; i++) begin
            reset_n = ($urandom_range(0, 49) != 0);
            load    = ($urandom_range(0, 24) == 0);
            start   = ($urandom_range(0, 7) == 0);
            enable  = ($urandom_range(0, 3) != 0);
            l_h = 4'($urandom_range(0, 2));
            l_t = 4'($urandom_range(0, 15));
            l_o = 4'($urandom_range(0, 15));
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
